// File: rtl/p_liu_pkg.sv
// Shared types and defaults for the P_Liu_Clock_Mod host-side job driver.
package p_liu_pkg;

    localparam int P_LIU_DATA_W = 16;
    localparam int P_LIU_CYC_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } p_liu_drv_state_t;

    // One completed job, laid out for result FIFOs and bench scoreboards.
    typedef struct packed {
        logic [P_LIU_DATA_W-1:0] operand;
        logic [P_LIU_DATA_W-1:0] value;
        logic [P_LIU_CYC_W-1:0]  cycles;
        logic                    timeout;
    } p_liu_result_t;

endpackage

// File: rtl/p_liu_job_driver_if.sv
// Job, result and processor-side signal bundle for p_liu_job_driver.
interface p_liu_job_driver_if
    import p_liu_pkg::*;
#(
    parameter int DATA_W = P_LIU_DATA_W,
    parameter int CYC_W  = P_LIU_CYC_W
);
    logic              job_valid;
    logic              job_ready;
    logic [DATA_W-1:0] job_operand;

    logic              proc_rst;
    logic [DATA_W-1:0] proc_input;
    logic [DATA_W-1:0] proc_output;

    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_operand;
    logic [DATA_W-1:0] res_value;
    logic [CYC_W-1:0]  res_cycles;
    logic              res_timeout;

    logic              busy;

    // master: the driver itself; slave: the host/consumer plus the processor.
    modport master (
        input  job_valid, job_operand, proc_output, res_ready,
        output job_ready, proc_rst, proc_input,
        output res_valid, res_operand, res_value, res_cycles, res_timeout, busy
    );

    modport slave (
        output job_valid, job_operand, proc_output, res_ready,
        input  job_ready, proc_rst, proc_input,
        input  res_valid, res_operand, res_value, res_cycles, res_timeout, busy
    );

endinterface

// File: rtl/p_liu_cycle_counter.sv
// Saturating up-counter with synchronous clear and enable; clear has priority.
module p_liu_cycle_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en && !(&count_reg)) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/p_liu_job_driver.sv
// Host-side job driver for P_Liu_Clock_Mod: reset, run, capture result and latency.
// Optional RUN watchdog enabled by defining P_LIU_DRIVER_TIMEOUT_EN.
module p_liu_job_driver
    import p_liu_pkg::*;
#(
    parameter int DATA_W     = P_LIU_DATA_W,
    parameter int RST_CYCLES = 3,
    parameter int CYC_W      = P_LIU_CYC_W,
    parameter int TIMEOUT    = 1000000
) (
    input logic                doubleClk,
    input logic                rst,
    p_liu_job_driver_if.master bus
);

    localparam logic [CYC_W-1:0] RST_LAST = CYC_W'(RST_CYCLES - 1);

    p_liu_drv_state_t  state_reg, state_next;
    logic              proc_rst_reg, proc_rst_next;
    logic [DATA_W-1:0] proc_input_reg, proc_input_next;
    logic              res_valid_reg, res_valid_next;
    logic [DATA_W-1:0] res_operand_reg, res_operand_next;
    logic [DATA_W-1:0] res_value_reg, res_value_next;
    logic [CYC_W-1:0]  res_cycles_reg, res_cycles_next;

    logic              cnt_clr;
    logic              cnt_en;
    logic [CYC_W-1:0]  count;

`ifdef P_LIU_DRIVER_TIMEOUT_EN
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(TIMEOUT - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_VAL  = CYC_W'(TIMEOUT);
    logic res_timeout_reg, res_timeout_next;
`else
    localparam logic [CYC_W-1:0] TIMEOUT_VAL = CYC_W'(TIMEOUT);
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_VAL;
`endif

    // One counter serves both phases: reset hold length, then run latency.
    p_liu_cycle_counter #(
        .W(CYC_W)
    ) u_cnt (
        .clk  (doubleClk),
        .rst  (rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .count(count)
    );

    always_comb begin
        state_next       = state_reg;
        proc_rst_next    = proc_rst_reg;
        proc_input_next  = proc_input_reg;
        res_valid_next   = res_valid_reg;
        res_operand_next = res_operand_reg;
        res_value_next   = res_value_reg;
        res_cycles_next  = res_cycles_reg;
`ifdef P_LIU_DRIVER_TIMEOUT_EN
        res_timeout_next = res_timeout_reg;
`endif
        cnt_clr          = 1'b0;
        cnt_en           = 1'b0;

        case (state_reg)
            IDLE: begin
                proc_rst_next = 1'b1;
                if (bus.job_valid) begin
                    proc_input_next = bus.job_operand;
                    cnt_clr         = 1'b1;
                    state_next      = RESET;
                end
            end
            RESET: begin
                if (count == RST_LAST) begin
                    proc_rst_next = 1'b0;
                    cnt_clr       = 1'b1;
                    state_next    = RUN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RUN: begin
                // Completion is tested first so it wins over the watchdog.
                if (bus.proc_output != '0) begin
                    res_value_next   = bus.proc_output;
                    res_operand_next = proc_input_reg;
                    res_cycles_next  = count;
                    res_valid_next   = 1'b1;
`ifdef P_LIU_DRIVER_TIMEOUT_EN
                    res_timeout_next = 1'b0;
`endif
                    state_next       = DONE;
                end
`ifdef P_LIU_DRIVER_TIMEOUT_EN
                else if (count == TIMEOUT_LAST) begin
                    res_value_next   = '0;
                    res_operand_next = proc_input_reg;
                    res_cycles_next  = TIMEOUT_VAL;
                    res_timeout_next = 1'b1;
                    res_valid_next   = 1'b1;
                    state_next       = DONE;
                end
`endif
                else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                // proc_rst stays low here so the processor keeps its output.
                if (bus.res_ready) begin
                    res_valid_next = 1'b0;
                    proc_rst_next  = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: begin
                proc_rst_next = 1'b1;
                state_next    = IDLE;
            end
        endcase
    end

    always_ff @(posedge doubleClk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            proc_rst_reg    <= 1'b1;
            proc_input_reg  <= '0;
            res_valid_reg   <= 1'b0;
            res_operand_reg <= '0;
            res_value_reg   <= '0;
            res_cycles_reg  <= '0;
`ifdef P_LIU_DRIVER_TIMEOUT_EN
            res_timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            proc_rst_reg    <= proc_rst_next;
            proc_input_reg  <= proc_input_next;
            res_valid_reg   <= res_valid_next;
            res_operand_reg <= res_operand_next;
            res_value_reg   <= res_value_next;
            res_cycles_reg  <= res_cycles_next;
`ifdef P_LIU_DRIVER_TIMEOUT_EN
            res_timeout_reg <= res_timeout_next;
`endif
        end
    end

    assign bus.job_ready   = (state_reg == IDLE) && !rst;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.proc_rst    = proc_rst_reg;
    assign bus.proc_input  = proc_input_reg;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_operand = res_operand_reg;
    assign bus.res_value   = res_value_reg;
    assign bus.res_cycles  = res_cycles_reg;
`ifdef P_LIU_DRIVER_TIMEOUT_EN
    assign bus.res_timeout = res_timeout_reg;
`else
    assign bus.res_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_p_liu_job_driver.sv
// Randomized bench for p_liu_job_driver with a latency-programmable processor model.
module tb_p_liu_job_driver;

    localparam int DATA_W     = 16;
    localparam int CYC_W      = 24;
    localparam int RST_CYCLES = 3;
    localparam int TIMEOUT    = 100;

    logic doubleClk = 1'b0;
    logic rst;

    always #5 doubleClk = ~doubleClk;

    p_liu_job_driver_if #(.DATA_W(DATA_W), .CYC_W(CYC_W)) bus ();

    p_liu_job_driver #(
        .DATA_W    (DATA_W),
        .RST_CYCLES(RST_CYCLES),
        .CYC_W     (CYC_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .doubleClk(doubleClk),
        .rst      (rst),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Processor model: answers f(input) once it has run `lat` cycles out of reset.
    int lat   = 0;
    bit never = 1'b0;
    bit junk  = 1'b0;
    int pcnt  = 0;

    function automatic logic [DATA_W-1:0] proc_f(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] t;
        t = x * 16'd7 + 16'd3;
        return t | 16'd1;
    endfunction

    always @(posedge doubleClk) begin
        if (bus.proc_rst) pcnt <= 0;
        else if (pcnt < 1000000) pcnt <= pcnt + 1;
    end

    assign bus.proc_output = bus.proc_rst ? (junk ? 16'hDEAD : 16'h0000)
                           : ((!never && pcnt >= lat) ? proc_f(bus.proc_input) : 16'h0000);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic accept_job(input logic [DATA_W-1:0] op);
        int n;
        n = 0;
        while (!bus.job_ready && n < 100) begin
            @(negedge doubleClk);
            n++;
        end
        check("job_ready_idle", bus.job_ready, 1);
        bus.job_valid   = 1'b1;
        bus.job_operand = op;
        @(negedge doubleClk);
    endtask

    task automatic run_job(input logic [DATA_W-1:0] op, input int l, input int hold,
                           input bit nv, input bit jk);
        int n;
        int bad;
        logic [DATA_W-1:0] exp_val;
        logic [CYC_W-1:0]  exp_cyc;
        bit                exp_to;
        int                exp_run;
        lat = l; never = nv; junk = jk;
        if (nv) begin
            exp_val = '0; exp_cyc = CYC_W'(TIMEOUT); exp_to = 1'b1; exp_run = TIMEOUT;
        end else begin
            exp_val = proc_f(op); exp_cyc = CYC_W'(l); exp_to = 1'b0; exp_run = l + 1;
        end
        // res_ready high before any result must be harmless
        bus.res_ready = 1'b1;
        accept_job(op);
        // a competing offer outside IDLE must not be consumed
        bus.job_valid   = 1'($urandom_range(0, 1));
        bus.job_operand = ~op;
        check("accept_state", {bus.busy, bus.job_ready, bus.proc_rst}, 3'b101);
        n = 0; bad = 0;
        while (bus.proc_rst && n < 100) begin
            if (bus.proc_input !== op) bad++;
            n++;
            @(negedge doubleClk);
        end
        bus.res_ready = 1'b0;
        check("rst_cycles", n, RST_CYCLES);
        check("rst_input_stable", bad, 0);
        n = 0;
        while (!bus.res_valid && n < 20000) begin
            n++;
            @(negedge doubleClk);
        end
        check("run_length", n, exp_run);
        check("res_operand", bus.res_operand, op);
        check("res_value", bus.res_value, exp_val);
        check("res_cycles", bus.res_cycles, exp_cyc);
        check("res_timeout", bus.res_timeout, exp_to);
        check("done_state", {bus.job_ready, bus.proc_rst, bus.busy}, 3'b001);
        bad = 0;
        repeat (hold) begin
            @(negedge doubleClk);
            if (bus.res_valid !== 1'b1 || bus.res_operand !== op || bus.res_value !== exp_val ||
                bus.res_cycles !== exp_cyc || bus.proc_rst !== 1'b0 || bus.job_ready !== 1'b0)
                bad++;
        end
        check("hold_stable", bad, 0);
        bus.job_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge doubleClk);
        bus.res_ready = 1'b0;
        check("handshake", {bus.res_valid, bus.proc_rst, bus.busy, bus.job_ready}, 4'b0101);
        $display("job op=%0d lat=%0d hold=%0d junk=%0b -> value=%0d cycles=%0d timeout=%0b",
                 op, l, hold, jk, exp_val, exp_cyc, exp_to);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.job_valid   = 1'b0;
        bus.job_operand = '0;
        bus.res_ready   = 1'b0;
        repeat (2) @(negedge doubleClk);
        check("reset_outputs",
              {bus.proc_rst, bus.proc_input, bus.res_valid, bus.res_operand, bus.res_value},
              {1'b1, 16'h0, 1'b0, 16'h0, 16'h0});
        check("reset_cycles", bus.res_cycles, 0);
        check("reset_flags", {bus.res_timeout, bus.busy, bus.job_ready}, 3'b000);
        rst = 1'b0;
        @(negedge doubleClk);
        check("job_ready_after_reset", bus.job_ready, 1);

        run_job(16'd5040, 40, 0, 1'b0, 1'b0);
        run_job(16'd30030, 12, 10, 1'b0, 1'b0);
        run_job(16'd360, 7, 2, 1'b0, 1'b0);
        run_job(16'd154, 3, 0, 1'b0, 1'b0);
        run_job(16'd77, 0, 1, 1'b0, 1'b0);
        run_job(16'd91, 5, 1, 1'b0, 1'b1);
        run_job(16'd0, 9, 0, 1'b0, 1'b1);
        run_job(16'd4321, TIMEOUT - 1, 0, 1'b0, 1'b0);

        // Mid-job reset: abort operand 561 while running.
        lat = 50; never = 1'b0; junk = 1'b0;
        accept_job(16'd561);
        bus.job_valid = 1'b0;
        n = 0;
        while (bus.proc_rst && n < 100) begin
            n++;
            @(negedge doubleClk);
        end
        repeat (10) @(negedge doubleClk);
        rst = 1'b1;
        #1;
        check("midrst_async",
              {bus.proc_rst, bus.busy, bus.job_ready, bus.res_valid}, 4'b1000);
        @(negedge doubleClk);
        rst = 1'b0;
        @(negedge doubleClk);
        check("midrst_recovered", {bus.res_valid, bus.job_ready, bus.busy}, 3'b010);
        run_job(16'd2310, 20, 1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_job(16'($urandom), int'($urandom_range(0, 60)), int'($urandom_range(0, 4)),
                    1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef P_LIU_DRIVER_TIMEOUT_EN
        run_job(16'd210, 0, 2, 1'b1, 1'b0);
`else
        never = 1'b1; junk = 1'b0;
        accept_job(16'd210);
        bus.job_valid = 1'b0;
        n = 0;
        repeat (10000) begin
            @(negedge doubleClk);
            if (bus.res_valid) n++;
        end
        check("no_timeout_wait", {n[15:0], bus.busy}, {16'd0, 1'b1});
        $display("job op=210 never responds -> still running after 10000 cycles");
        rst = 1'b1;
        @(negedge doubleClk);
        rst = 1'b0;
        @(negedge doubleClk);
        never = 1'b0;
        check("no_timeout_recover", {bus.busy, bus.job_ready}, 2'b01);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
